digit_overlay_render: RTL and testbench
=======================================

# digit_overlay_render

Renders a recognized digit back onto the live LCD video stream as a seven-segment glyph, plus an outline of the detected character bounding box. It sits downstream of the digit recognizer and upstream of the LCD output: recognition decodes pixels to a digit, this block encodes the digit back to pixels. Inputs are frame-latched so a glyph never tears mid-frame.

## Interface
- ORIGIN_X, 16: glyph left column.
- ORIGIN_Y, 16: glyph top row.
- DIG_W, 32: glyph width, pixels.
- DIG_H, 64: glyph height, pixels; must be even.
- SEG_T, 6: segment thickness, pixels; must be even and satisfy 2*SEG_T < DIG_W and SEG_T < DIG_H/2.
- FG_COLOR, 24'hFF0000: glyph colour, RGB888.
- BOX_COLOR, 24'h00FF00: bounding-box outline colour.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous active-low reset.
- x, y  in  12 each  current pixel position.
- i_hs, i_vs, i_de  in  1 each  input timing; i_vs is active-high.
- i_data  in  24  input pixel.
- digit_in  in  4  recognized digit; 0-9 draw a glyph, 10-15 draw blank.
- digit_valid  in  1  one-cycle strobe that qualifies digit_in.
- char_up, char_down, char_left, char_right  in  12 each  box edges.
- box_valid  in  1  one-cycle strobe that qualifies the box edges.
- o_hs, o_vs, o_de  out  1 each  timing delayed by 1 cycle.
- o_data  out  24  composited pixel.

## Operation
- **Pending registers.** `digit_pend` and `box_pend` capture their inputs on each valid strobe; the last strobe wins. `box_pend_ok` is set when any box is captured. `dig_pend_ok` clears at reset.
- **Frame commit.** A rising edge of i_vs is detected as i_vs high and the registered i_vs low. On that edge, the pending values copy to the active registers `digit_act`, `box_act` and `box_act_ok`.
- **Strobe on the commit cycle.** If a strobe coincides with the commit cycle, the strobed value bypasses pending and commits directly.
- **Stable during the frame.** The active registers are read only for drawing and change only at commit.
- **Glyph geometry.** Relative coordinates are rx = x − ORIGIN_X and ry = y − ORIGIN_Y, in 12-bit unsigned arithmetic. The pixel is in the glyph when x ≥ ORIGIN_X, x < ORIGIN_X+DIG_W, y ≥ ORIGIN_Y and y < ORIGIN_Y+DIG_H. With H2 = DIG_H/2:
  - a: ry < SEG_T.
  - b: rx ≥ DIG_W−SEG_T and ry < H2.
  - c: rx ≥ DIG_W−SEG_T and ry ≥ H2.
  - d: ry ≥ DIG_H−SEG_T.
  - e: rx < SEG_T and ry ≥ H2.
  - f: rx < SEG_T and ry < H2.
  - g: ry in [H2−SEG_T/2, H2+SEG_T/2).
- **Segment masks.** Masks use the standard common-cathode encoding. 1 uses b and c; 7 uses a, b and c. Codes 10-15 give an all-zero mask.
- **Box outline.** This applies only when `box_act_ok` is set. A pixel is on the box when either of these holds:
  - x equals char_left or char_right, and y is in [char_up, char_down];
  - y equals char_up or char_down, and x is in [char_left, char_right].
- **Degenerate box.** If left > right or up > down, no box is drawn.
- **Composite priority.** A lit segment gives FG_COLOR; otherwise a box pixel gives BOX_COLOR; otherwise i_data.
- **Blanking.** When i_de is low, o_data = i_data with no overlay.

## Timing
- Latency is exactly 1 cycle on all outputs. o_hs, o_vs, o_de and o_data are registered from same-cycle inputs.
- Reset, when rst_n is low at a clk edge:
  - o_hs, o_vs, o_de and o_data go to 0.
  - The pending and active registers clear; `digit_act` = 4'hF, so blank is drawn.
  - The valid flags clear and the i_vs edge register goes to 0.
- Reset mid-frame: overlay stays off until the first commit after reset.
- A strobe during a frame takes effect at the next i_vs rising edge, never in the current frame.
- Strobes while i_vs is held high are captured to pending and commit on the next edge.

## Structure
- Shared package `lcd_overlay_pkg`:
  - segment bit-index constants SEG_A..SEG_G, with bit 0 = a;
  - the DIGIT_BLANK = 4'hF constant;
  - RGB888 colour constants.
- Sub-module `seg7_decode`: combinational, 4-bit digit in, 7-bit mask out. It is reused by any future score or label overlays.
- Top level holds the frame-latch registers, geometry compare and output register.

## Test plan
- **Reset.** Hold rst_n=0 for 3 cycles with i_de=1 and i_data=24'h123456. Required: all outputs 0; then o_data=24'h123456 one cycle after release, with no overlay.
- **Frame latch.** Strobe digit_in=8 mid-frame. Required: the current frame is unchanged; after the next i_vs rise, (x,y)=(20,17) gives 24'hFF0000 and (x,y)=(31,48) gives 24'hFF0000.
- **Digit 1 shape.** Commit digit 1. Required: (46,20) is red; (18,20) and (30,17) pass i_data.
- **Commit-cycle bypass and blank.** Strobe digit_in=3 exactly on the i_vs rising-edge cycle: required, it is drawn in that frame. Then commit digit_in=12: required, no red pixels anywhere.
- **Box.** Commit box up=100, down=150, left=200, right=260. Required: (200,120) and (230,150) give 24'h00FF00; (201,120) passes i_data. With left=300 and right=260, no box is drawn.
- **Priority and blanking.** Use a box overlapping a lit segment: the overlap pixel gives FG_COLOR. With i_de=0 inside the glyph, o_data = i_data.

Source files
------------

// File: rtl/lcd_overlay_pkg.sv
// Shared definitions for LCD overlay blocks.
//   - Segment bit indices for 7-bit seven-segment masks (bit 0 = a ... bit 6 = g).
//   - DIGIT_BLANK: the digit code that draws nothing.
//   - RGB888 colour constants.
//   - box_t: one character bounding box (inclusive edges, pixel coordinates).
package lcd_overlay_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    localparam logic [23:0] COLOR_BLACK = 24'h000000;
    localparam logic [23:0] COLOR_RED   = 24'hFF0000;
    localparam logic [23:0] COLOR_GREEN = 24'h00FF00;
    localparam logic [23:0] COLOR_BLUE  = 24'h0000FF;

    typedef struct packed {
        logic [11:0] up;
        logic [11:0] down;
        logic [11:0] left;
        logic [11:0] right;
    } box_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment encoder, common-cathode (1 = segment lit).
// Ports:
//   digit  in  4  digit code; 0-9 give a glyph, 10-15 give an all-zero mask
//   mask   out 7  segment mask, bit SEG_A..SEG_G
module seg7_decode
    import lcd_overlay_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] mask
);

    // Bit order in the literals below is {g,f,e,d,c,b,a}.
    always_comb begin
        mask = 7'b0000000;
        case (digit)
            4'd0:    mask = 7'b0111111;
            4'd1:    mask = 7'b0000110;
            4'd2:    mask = 7'b1011011;
            4'd3:    mask = 7'b1001111;
            4'd4:    mask = 7'b1100110;
            4'd5:    mask = 7'b1101101;
            4'd6:    mask = 7'b1111101;
            4'd7:    mask = 7'b0000111;
            4'd8:    mask = 7'b1111111;
            4'd9:    mask = 7'b1101111;
            default: mask = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/digit_overlay_render.sv
// Draws a recognised digit as a seven-segment glyph plus the character
// bounding-box outline onto the live LCD stream. Digit and box are latched
// at each i_vs rising edge so the overlay never changes mid-frame.
// Ports:
//   clk, rst_n                  pixel clock, synchronous active-low reset
//   x, y                        current pixel position
//   i_hs, i_vs, i_de, i_data    input timing / pixel (i_vs active-high)
//   digit_in, digit_valid       digit and its one-cycle qualifying strobe
//   char_up/down/left/right     box edges (inclusive)
//   box_valid                   one-cycle strobe qualifying the box edges
//   o_hs, o_vs, o_de, o_data    outputs, all registered with 1-cycle latency
//
// Strobe semantics: digit_valid / box_valid are single-cycle qualifiers with
// no ready; a value is accepted on every cycle its strobe is high, the last
// one before a frame commit wins, and a strobe on the commit cycle itself
// goes straight to the active registers.
module digit_overlay_render
    import lcd_overlay_pkg::*;
#(
    parameter int          ORIGIN_X  = 16,
    parameter int          ORIGIN_Y  = 16,
    parameter int          DIG_W     = 32,
    parameter int          DIG_H     = 64,
    parameter int          SEG_T     = 6,
    parameter logic [23:0] FG_COLOR  = COLOR_RED,
    parameter logic [23:0] BOX_COLOR = COLOR_GREEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic        i_de,
    input  logic [23:0] i_data,
    input  logic [3:0]  digit_in,
    input  logic        digit_valid,
    input  logic [11:0] char_up,
    input  logic [11:0] char_down,
    input  logic [11:0] char_left,
    input  logic [11:0] char_right,
    input  logic        box_valid,
    output logic        o_hs,
    output logic        o_vs,
    output logic        o_de,
    output logic [23:0] o_data
);

    localparam logic [11:0] OX    = 12'(ORIGIN_X);
    localparam logic [11:0] OY    = 12'(ORIGIN_Y);
    localparam logic [11:0] X_END = 12'(ORIGIN_X + DIG_W);
    localparam logic [11:0] Y_END = 12'(ORIGIN_Y + DIG_H);
    localparam logic [11:0] T     = 12'(SEG_T);
    localparam logic [11:0] H2    = 12'(DIG_H / 2);
    localparam logic [11:0] X_RT  = 12'(DIG_W - SEG_T);
    localparam logic [11:0] Y_BOT = 12'(DIG_H - SEG_T);
    localparam logic [11:0] G_LO  = 12'(DIG_H / 2 - SEG_T / 2);
    localparam logic [11:0] G_HI  = 12'(DIG_H / 2 + SEG_T / 2);

    // Frame-latch state
    logic [3:0] digit_pend, digit_act;
    logic       dig_pend_ok;
    box_t       box_pend, box_act;
    logic       box_pend_ok, box_act_ok;
    logic       vs_q;
    logic       commit;
    box_t       box_in;

    assign commit = i_vs && !vs_q;
    assign box_in = '{up: char_up, down: char_down, left: char_left, right: char_right};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_pend  <= DIGIT_BLANK;
            digit_act   <= DIGIT_BLANK;
            dig_pend_ok <= 1'b0;
            box_pend    <= '0;
            box_act     <= '0;
            box_pend_ok <= 1'b0;
            box_act_ok  <= 1'b0;
            vs_q        <= 1'b0;
        end else begin
            vs_q <= i_vs;
            if (digit_valid) begin
                digit_pend  <= digit_in;
                dig_pend_ok <= 1'b1;
            end
            if (box_valid) begin
                box_pend    <= box_in;
                box_pend_ok <= 1'b1;
            end
            if (commit) begin
                // A strobe on the commit cycle bypasses pending.
                if (digit_valid)      digit_act <= digit_in;
                else if (dig_pend_ok) digit_act <= digit_pend;
                else                  digit_act <= DIGIT_BLANK;
                box_act    <= box_valid ? box_in : box_pend;
                box_act_ok <= box_valid | box_pend_ok;
            end
        end
    end

    // Glyph geometry
    logic [11:0] rx, ry;
    logic        in_glyph;
    logic [6:0]  seg_hit;
    logic [6:0]  seg_mask;
    logic        seg_lit;

    assign rx = x - OX;
    assign ry = y - OY;

    always_comb begin
        seg_hit  = 7'b0000000;
        in_glyph = (x >= OX) && (x < X_END) && (y >= OY) && (y < Y_END);
        if (in_glyph) begin
            seg_hit[SEG_A] = ry < T;
            seg_hit[SEG_B] = (rx >= X_RT) && (ry < H2);
            seg_hit[SEG_C] = (rx >= X_RT) && (ry >= H2);
            seg_hit[SEG_D] = ry >= Y_BOT;
            seg_hit[SEG_E] = (rx < T) && (ry >= H2);
            seg_hit[SEG_F] = (rx < T) && (ry < H2);
            seg_hit[SEG_G] = (ry >= G_LO) && (ry < G_HI);
        end
    end

    seg7_decode u_seg7_decode (
        .digit (digit_act),
        .mask  (seg_mask)
    );

    assign seg_lit = |(seg_hit & seg_mask);

    // Box outline; an inverted box (left > right or up > down) draws nothing.
    logic box_ok, on_vert, on_horz, box_hit;

    assign box_ok  = box_act_ok && (box_act.left <= box_act.right) && (box_act.up <= box_act.down);
    assign on_vert = ((x == box_act.left) || (x == box_act.right)) &&
                     (y >= box_act.up) && (y <= box_act.down);
    assign on_horz = ((y == box_act.up) || (y == box_act.down)) &&
                     (x >= box_act.left) && (x <= box_act.right);
    assign box_hit = box_ok && (on_vert || on_horz);

    // Composite and output register
    logic [23:0] pix;

    always_comb begin
        pix = i_data;
        if (i_de) begin
            if (seg_lit)      pix = FG_COLOR;
            else if (box_hit) pix = BOX_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_hs   <= 1'b0;
            o_vs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= '0;
        end else begin
            o_hs   <= i_hs;
            o_vs   <= i_vs;
            o_de   <= i_de;
            o_data <= pix;
        end
    end

endmodule

// File: tb/tb_digit_overlay_render.sv
// Directed bench for digit_overlay_render: frame latching, glyph shapes,
// commit-cycle bypass, blank codes, box outline, priority and blanking.
module tb_digit_overlay_render;

    localparam logic [23:0] RED   = 24'hFF0000;
    localparam logic [23:0] GREEN = 24'h00FF00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] x, y;
    logic        i_hs, i_vs, i_de;
    logic [23:0] i_data;
    logic [3:0]  digit_in;
    logic        digit_valid;
    logic [11:0] char_up, char_down, char_left, char_right;
    logic        box_valid;
    logic        o_hs, o_vs, o_de;
    logic [23:0] o_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [23:0] exp_q[$];

    digit_overlay_render dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .i_hs        (i_hs),
        .i_vs        (i_vs),
        .i_de        (i_de),
        .i_data      (i_data),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .char_up     (char_up),
        .char_down   (char_down),
        .char_left   (char_left),
        .char_right  (char_right),
        .box_valid   (box_valid),
        .o_hs        (o_hs),
        .o_vs        (o_vs),
        .o_de        (o_de),
        .o_data      (o_data)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One active pixel; expected colour goes through the scoreboard queue.
    task automatic drive_px(input string tag, input int px, input int py, input logic de,
                            input logic [23:0] data, input logic [23:0] exp);
        x = 12'(px); y = 12'(py); i_de = de; i_data = data;
        i_vs = 1'b0; i_hs = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        check_eq(tag, {8'h0, o_data}, {8'h0, exp_q.pop_front()});
        digit_valid = 1'b0;
        box_valid   = 1'b0;
    endtask

    task automatic strobe_digit(input logic [3:0] d);
        digit_in = d; digit_valid = 1'b1;
    endtask

    task automatic strobe_box(input int u, input int dn, input int l, input int r);
        char_up = 12'(u); char_down = 12'(dn); char_left = 12'(l); char_right = 12'(r);
        box_valid = 1'b1;
    endtask

    // One vertical-sync cycle (commit), then i_vs returns low.
    task automatic vsync();
        x = '0; y = '0; i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b1; i_data = 24'hABCDEF;
        @(posedge clk); #1;
        check_eq("vs_out", {31'h0, o_vs}, 32'h1);
        digit_valid = 1'b0;
        box_valid   = 1'b0;
        i_vs = 1'b0;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0; x = '0; y = '0; i_hs = 1'b1; i_vs = 1'b1; i_de = 1'b1;
        i_data = 24'h123456; digit_in = '0; digit_valid = 1'b0;
        char_up = '0; char_down = '0; char_left = '0; char_right = '0; box_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("rst_data", {8'h0, o_data}, 32'h0);
            check_eq("rst_ctl", {29'h0, o_hs, o_vs, o_de}, 32'h0);
        end
        rst_n = 1'b1; i_vs = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_data", {8'h0, o_data}, 32'h00123456);
        check_eq("post_rst_ctl", {29'h0, o_hs, o_vs, o_de}, 32'h5);

        // Frame latch: digit 8 strobed mid-frame, visible only after i_vs rise
        vsync();
        strobe_digit(4'd8);
        drive_px("latch_strobe_px", 20, 17, 1'b1, 24'h111111, 24'h111111);
        drive_px("latch_same_frame", 20, 17, 1'b1, 24'h222222, 24'h222222);
        drive_px("latch_same_frame_g", 31, 48, 1'b1, 24'h333333, 24'h333333);
        vsync();
        drive_px("d8_seg_a", 20, 17, 1'b1, 24'h444444, RED);
        drive_px("d8_seg_g", 31, 48, 1'b1, 24'h555555, RED);
        drive_px("d8_outside", 10, 10, 1'b1, 24'h565656, 24'h565656);
        drive_px("d8_hole", 31, 25, 1'b1, 24'h575757, 24'h575757);

        // Digit 1 shape
        strobe_digit(4'd1);
        drive_px("d1_pending", 18, 20, 1'b1, 24'h666666, RED);
        vsync();
        drive_px("d1_seg_b", 46, 20, 1'b1, 24'h777777, RED);
        drive_px("d1_no_f", 18, 20, 1'b1, 24'h888888, 24'h888888);
        drive_px("d1_no_a", 30, 17, 1'b1, 24'h999999, 24'h999999);
        drive_px("d1_seg_c", 47, 79, 1'b1, 24'h9A9A9A, RED);
        drive_px("d1_past_right", 48, 20, 1'b1, 24'h9B9B9B, 24'h9B9B9B);

        // Commit-cycle bypass: digit 3 strobed with the i_vs rise
        strobe_digit(4'd3);
        vsync();
        drive_px("d3_seg_a", 20, 17, 1'b1, 24'hAAAAAA, RED);
        drive_px("d3_seg_b", 46, 40, 1'b1, 24'hBBBBBB, RED);
        drive_px("d3_no_f", 18, 40, 1'b1, 24'hCCCCCC, 24'hCCCCCC);
        drive_px("d3_seg_d", 30, 79, 1'b1, 24'hCDCDCD, RED);

        // Blank code 12
        strobe_digit(4'd12);
        drive_px("blank_pending", 20, 17, 1'b1, 24'hDDDDDD, RED);
        vsync();
        drive_px("blank_a", 20, 17, 1'b1, 24'hEEEEEE, 24'hEEEEEE);
        drive_px("blank_g", 31, 48, 1'b1, 24'h010101, 24'h010101);
        drive_px("blank_b", 46, 20, 1'b1, 24'h020202, 24'h020202);

        // Box outline
        strobe_box(100, 150, 200, 260);
        drive_px("box_pending", 200, 120, 1'b1, 24'h030303, 24'h030303);
        vsync();
        drive_px("box_left", 200, 120, 1'b1, 24'h040404, GREEN);
        drive_px("box_bottom", 230, 150, 1'b1, 24'h050505, GREEN);
        drive_px("box_inside", 201, 120, 1'b1, 24'h060606, 24'h060606);
        drive_px("box_right", 260, 100, 1'b1, 24'h070707, GREEN);
        drive_px("box_below", 230, 151, 1'b1, 24'h080808, 24'h080808);

        // Degenerate box: left > right
        strobe_box(100, 150, 300, 260);
        vsync();
        drive_px("degen_left", 300, 120, 1'b1, 24'h090909, 24'h090909);
        drive_px("degen_right", 260, 120, 1'b1, 24'h0A0A0A, 24'h0A0A0A);
        drive_px("degen_top", 280, 100, 1'b1, 24'h0B0B0B, 24'h0B0B0B);

        // Priority and blanking: box overlaps digit 1 segment b
        strobe_digit(4'd1);
        strobe_box(16, 40, 16, 47);
        vsync();
        drive_px("prio_overlap", 47, 16, 1'b1, 24'h0C0C0C, RED);
        drive_px("prio_box_only", 16, 30, 1'b1, 24'h0D0D0D, GREEN);
        drive_px("blank_de_low", 47, 20, 1'b0, 24'h0E0E0E, 24'h0E0E0E);
        check_eq("de_low_out", {31'h0, o_de}, 32'h0);

        // Reset mid-frame: overlay off until the next commit
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("midrst_data", {8'h0, o_data}, 32'h0);
        rst_n = 1'b1;
        drive_px("midrst_seg", 47, 16, 1'b1, 24'h0F0F0F, 24'h0F0F0F);
        drive_px("midrst_box", 16, 30, 1'b1, 24'h101010, 24'h101010);
        vsync();
        drive_px("midrst_after_commit", 47, 16, 1'b1, 24'h121212, 24'h121212);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
